// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Holds the FSM state encoding, the default read-data width and the
// access-latency counter width (4 bits, so MEM_LAT may be 1..15).
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_CNT_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times one fixed-latency memory access.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   load_i     load load_val_i (takes precedence over dec_i)
//   load_val_i value to load, normally MEM_LAT-1
//   dec_i      decrement by one; saturates at zero
//   zero_o     count is zero (last access cycle while busy)
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [ARB_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter granting one of two requesters (A = fetch, B = data) a shared
// memory port for a fixed MEM_LAT-cycle access, then pulsing the owner's
// done for one cycle with the captured read data.
// Optional build macro MEM_PORT_ARB_FIXED_PRIO_EN: when defined, A always
// wins simultaneous requests; otherwise priority alternates round-robin.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_a_i / req_b_i      requests, held until the matching done
//   we_a_i / we_b_i        write enables, held with the request
//   mem_rdata_i            memory read data, valid while mem_en_o is high
//   sel_o                  word-mux select (1 = A), holds last owner when idle
//   gnt_a_o / gnt_b_o      owner indication for the access cycles
//   mem_en_o, mem_we_o     memory enable, owner's write enable gated by enable
//   done_a_o / done_b_o    one-cycle completion pulses
//   rdata_o                read data captured on the last access cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_a_i,
    input  logic              req_b_i,
    input  logic              we_a_i,
    input  logic              we_b_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              sel_o,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic              done_a_o,
    output logic              done_b_o,
    output logic [DATA_W-1:0] rdata_o
);

    if ((MEM_LAT < 1) || (MEM_LAT > ((1 << ARB_CNT_W) - 1))) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              mem_en_q, mem_en_d;
    logic              done_a_q, done_a_d;
    logic              done_b_q, done_b_d;
    logic              prio_q, prio_d;  // 0 = A wins a tie, 1 = B wins
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_a;
    logic              cnt_load, cnt_dec, cnt_zero;

    mem_lat_counter u_lat_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (ARB_CNT_W'(MEM_LAT - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        mem_en_d = mem_en_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        prio_d   = prio_q;
        rdata_d  = rdata_q;
        grant_a  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (req_a_i || req_b_i) begin
                    grant_a  = req_a_i && (!req_b_i || !prio_q);
                    state_d  = ARB_BUSY;
                    sel_d    = grant_a;
                    gnt_a_d  = grant_a;
                    gnt_b_d  = !grant_a;
                    mem_en_d = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            ARB_BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // Capture on writes too; the owner simply ignores it.
                    rdata_d  = mem_rdata_i;
                    state_d  = ARB_DONE;
                    gnt_a_d  = 1'b0;
                    gnt_b_d  = 1'b0;
                    mem_en_d = 1'b0;
                    done_a_d = sel_q;
                    done_b_d = !sel_q;
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
                    prio_d   = 1'b0;
`else
                    // Hand priority to the requester that was not just served.
                    prio_d   = sel_q;
`endif
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            sel_q    <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            mem_en_q <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            prio_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            mem_en_q <= mem_en_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            prio_q   <= prio_d;
            rdata_q  <= rdata_d;
        end
    end

    assign sel_o    = sel_q;
    assign gnt_a_o  = gnt_a_q;
    assign gnt_b_o  = gnt_b_q;
    assign mem_en_o = mem_en_q;
    assign mem_we_o = mem_en_q && (sel_q ? we_a_i : we_b_i);
    assign done_a_o = done_a_q;
    assign done_b_o = done_b_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 2. Each table row gives
// the inputs applied before a clock edge and the outputs expected after it.
// Honours MEM_PORT_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic          rst, ra, rb, wa, wb;
        logic [DW-1:0] md;
        logic          sel, ga, gb, en, we, da, db;
        logic [DW-1:0] rd;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          sel, gnt_a, gnt_b, mem_en, mem_we, done_a, done_b;
    logic [DW-1:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W  (DW),
        .MEM_LAT (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .we_a_i      (we_a),
        .we_b_i      (we_b),
        .mem_rdata_i (mem_rdata),
        .sel_o       (sel),
        .gnt_a_o     (gnt_a),
        .gnt_b_o     (gnt_b),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .done_a_o    (done_a),
        .done_b_o    (done_b),
        .rdata_o     (rdata)
    );

    task automatic chk(input string name, input int idx, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_v, ra, rb, wa, wb, input logic [DW-1:0] md,
                                input logic s, ga, gb, en, we, da, db,
                                input logic [DW-1:0] rd);
        vec_t v;
        v.rst = rst_v; v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb; v.md = md;
        v.sel = s; v.ga = ga; v.gb = gb; v.en = en; v.we = we; v.da = da; v.db = db;
        v.rd = rd;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] d_be, d_12, d_11, d_22, d_33, d_44;
        int done_seen, en_cnt, done_cnt;
        d_be = 32'hDEADBEEF; d_12 = 32'h12345678; d_11 = 32'h11111111;
        d_22 = 32'h22222222; d_33 = 32'h33333333; d_44 = 32'h44444444;

        //            rst ra rb wa wb md      sel ga gb en we da db rd
        vecs[0]  = mk(1, 0, 0, 0, 0, '0,     0, 0, 0, 0, 0, 0, 0, '0);
        // Single read from A.
        vecs[1]  = mk(0, 1, 0, 0, 0, d_be,   1, 1, 0, 1, 0, 0, 0, '0);
        vecs[2]  = mk(0, 1, 0, 0, 0, d_be,   1, 1, 0, 1, 0, 0, 0, '0);
        vecs[3]  = mk(0, 1, 0, 0, 0, d_be,   1, 0, 0, 0, 0, 1, 0, d_be);
        vecs[4]  = mk(0, 0, 0, 0, 0, '0,     1, 0, 0, 0, 0, 0, 0, d_be);
        // Single write from B.
        vecs[5]  = mk(0, 0, 1, 0, 1, d_12,   0, 0, 1, 1, 1, 0, 0, d_be);
        vecs[6]  = mk(0, 0, 1, 0, 1, d_12,   0, 0, 1, 1, 1, 0, 0, d_be);
        vecs[7]  = mk(0, 0, 1, 0, 1, d_12,   0, 0, 0, 0, 0, 0, 1, d_12);
        vecs[8]  = mk(0, 0, 0, 0, 0, '0,     0, 0, 0, 0, 0, 0, 0, d_12);
        // Both requesting and held: A first (prio back to A after B's access).
        vecs[9]  = mk(0, 1, 1, 0, 0, d_11,   1, 1, 0, 1, 0, 0, 0, d_12);
        vecs[10] = mk(0, 1, 1, 0, 0, d_11,   1, 1, 0, 1, 0, 0, 0, d_12);
        vecs[11] = mk(0, 1, 1, 0, 0, d_11,   1, 0, 0, 0, 0, 1, 0, d_11);
        vecs[12] = mk(0, 1, 1, 0, 0, d_22,   1, 0, 0, 0, 0, 0, 0, d_11);
        // Second grant: B when round-robin, A again when fixed.
        vecs[13] = mk(0, 1, 1, 0, 0, d_22,   FIXED, FIXED, !FIXED, 1, 0, 0, 0, d_11);
        vecs[14] = mk(0, 1, 1, 0, 0, d_22,   FIXED, FIXED, !FIXED, 1, 0, 0, 0, d_11);
        vecs[15] = mk(0, 1, 1, 0, 0, d_22,   FIXED, 0, 0, 0, 0, FIXED, !FIXED, d_22);
        vecs[16] = mk(0, 1, 1, 1, 0, d_33,   FIXED, 0, 0, 0, 0, 0, 0, d_22);
        // Third grant is A in both builds; A writes this time.
        vecs[17] = mk(0, 1, 1, 1, 0, d_33,   1, 1, 0, 1, 1, 0, 0, d_22);
        vecs[18] = mk(0, 1, 1, 1, 0, d_33,   1, 1, 0, 1, 1, 0, 0, d_22);
        vecs[19] = mk(0, 1, 1, 1, 0, d_33,   1, 0, 0, 0, 0, 1, 0, d_33);
        vecs[20] = mk(0, 1, 1, 1, 0, d_44,   1, 0, 0, 0, 0, 0, 0, d_33);
        // A drops for the idle cycle: B slips in; A's re-request waits.
        vecs[21] = mk(0, 0, 1, 1, 0, d_44,   0, 0, 1, 1, 0, 0, 0, d_33);
        vecs[22] = mk(0, 1, 1, 1, 0, d_44,   0, 0, 1, 1, 0, 0, 0, d_33);
        vecs[23] = mk(0, 1, 1, 1, 0, d_44,   0, 0, 0, 0, 0, 0, 1, d_44);
        vecs[24] = mk(0, 0, 0, 0, 0, '0,     0, 0, 0, 0, 0, 0, 0, d_44);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; req_a = vecs[i].ra; req_b = vecs[i].rb;
            we_a = vecs[i].wa; we_b = vecs[i].wb; mem_rdata = vecs[i].md;
            @(posedge clk);
            #1;
            chk("sel",    i, DW'(sel),    DW'(vecs[i].sel));
            chk("gnt_a",  i, DW'(gnt_a),  DW'(vecs[i].ga));
            chk("gnt_b",  i, DW'(gnt_b),  DW'(vecs[i].gb));
            chk("mem_en", i, DW'(mem_en), DW'(vecs[i].en));
            chk("mem_we", i, DW'(mem_we), DW'(vecs[i].we));
            chk("done_a", i, DW'(done_a), DW'(vecs[i].da));
            chk("done_b", i, DW'(done_b), DW'(vecs[i].db));
            chk("rdata",  i, rdata,       vecs[i].rd);
        end

        // Reset during the second busy cycle abandons the access.
        @(negedge clk);
        req_a = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        chk("rst_seq_busy1_gnt_a", 0, DW'(gnt_a), 32'd1);
        @(posedge clk); #1;
        chk("rst_seq_busy2_en", 1, DW'(mem_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq_en",    2, DW'(mem_en), 32'd0);
        chk("rst_seq_gnt",   2, DW'(gnt_a | gnt_b), 32'd0);
        chk("rst_seq_sel",   2, DW'(sel), 32'd0);
        chk("rst_seq_rdata", 2, rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done_a || done_b) done_seen++;
        end
        chk("rst_seq_no_done", 3, DW'(done_seen), 32'd0);

        // A drops its request in the first busy cycle; access still completes.
        @(negedge clk);
        req_a = 1'b1; mem_rdata = 32'h66666666;
        @(posedge clk); #1;
        en_cnt = mem_en ? 1 : 0;
        done_cnt = 0;
        @(negedge clk);
        req_a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_en) en_cnt++;
            if (done_a) done_cnt++;
        end
        chk("drop_seq_en_cycles", 0, DW'(en_cnt),   32'd2);
        chk("drop_seq_done_a",    0, DW'(done_cnt), 32'd1);
        chk("drop_seq_rdata",     0, rdata,         32'h66666666);
        chk("drop_seq_idle_gnt",  0, DW'(gnt_a | gnt_b | mem_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for a single shared memory port. Port A is instruction fetch and port B is data access. The block grants one requester at a time and counts a fixed multi-cycle access. It drives the select line of the 32-bit 2:1 word muxes that steer address and write data onto the port, and it returns a one-cycle completion pulse with latched read data. It sits between the fetch/memory stages and the shared memory.

## Interface
- DATA_W, 32, read-data width.
- MEM_LAT, 2, memory access cycles per grant; legal range 1..15.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- ReqA / ReqB  in  1  access request; held high until the matching Done.
- WeA / WeB  in  1  write enable of each requester; held with the request.
- MemRData  in  DATA_W  memory read data, valid combinationally while MemEn is high.
- Sel  out  1  word-mux select (1 = requester A). Resets to 0 and holds the last owner when idle.
- GntA / GntB  out  1  owner indication, high from grant through the last access cycle. Reset 0.
- MemEn  out  1  memory port enable. Reset 0.
- MemWe  out  1  owner's write enable, gated by MemEn. Reset 0.
- DoneA / DoneB  out  1  one-cycle completion pulse. Reset 0.
- RData  out  DATA_W  read data captured on the last access cycle, held until the next capture. Reset 0.

## Operation
- States:
  - IDLE: no grant outstanding.
  - BUSY: an access is in progress.
  - DONE: completion cycle.
- IDLE → BUSY when any Req is high at the edge.
  - Only one requester high: grant it.
  - Both high: grant the requester named by the priority bit Prio (0 = A, 1 = B; reset 0).
  - On entering BUSY: Sel and Gnt register the owner, and the counter loads MEM_LAT-1.
- BUSY:
  - MemEn=1; MemWe is the owner's We; the counter decrements each edge.
  - When the counter is 0 at an edge, MemRData is captured into RData (captured on writes too) and the state moves to DONE.
- DONE:
  - Gnt and MemEn are low; the owner's Done is high for exactly 1 cycle.
  - Prio is set to the non-owner.
  - Next state is IDLE unconditionally.
- The requester must drop Req during its Done cycle. A Req still high in IDLE is treated as a new request.
- Req deasserted during BUSY is ignored; the access completes and Done still pulses.
- A Req arriving while BUSY or DONE waits; it is sampled first in IDLE.
- Reset asserted in any state: the next edge forces IDLE and all outputs to their reset values. The access is abandoned and no Done is issued.
- MEM_LAT=0 is illegal; flag it with an elaboration-time check.

## Timing
- Req high before edge E0 in IDLE: Gnt and MemEn go high after E0.
- MemEn stays high for exactly MEM_LAT cycles.
- Done and a valid RData appear after edge E(MEM_LAT).
- IDLE is re-entered after E(MEM_LAT+1).
- Request-to-Done latency is MEM_LAT+1 edges. Minimum spacing between back-to-back grants is MEM_LAT+2 cycles.
- All outputs are registered except MemWe, which is Gnt-qualified We.

## Configuration
- MEM_PORT_ARB_FIXED_PRIO_EN
  - Defined: Prio is tied to 0 and never updates, so A always wins simultaneous requests. B can starve under continuous A traffic.
  - Undefined: round-robin as described in Operation.

## Structure
- Shared package holds:
  - state encoding constants (ARB_IDLE, ARB_BUSY, ARB_DONE);
  - the default DATA_W;
  - the counter width constant (4 bits, covering MEM_LAT ≤ 15).
- One natural sub-module: mem_lat_counter.
  - Inputs: load, load value, decrement enable.
  - Output: zero flag.
- Address and write-data 2:1 word muxes are instantiated at the level above, driven by Sel.

## Test plan
- Reset, then ReqA=1 only, MEM_LAT=2, MemRData=0xDEADBEEF: GntA/MemEn high for 2 cycles, Sel=1, DoneA pulses at edge 3, RData=0xDEADBEEF.
- ReqA and ReqB raised in the same cycle, both held after Done (round-robin build): A served first. B is granted in the IDLE cycle after DoneA, so grants alternate A, B, A.
- Same stimulus with MEM_PORT_ARB_FIXED_PRIO_EN defined: A granted first. Drop ReqA for one cycle after DoneA, and B is granted in that gap.
- ReqB with WeB=1 while ReqA is low: MemWe=1 for exactly MEM_LAT cycles, Sel=0, then DoneB pulses; a single request is granted immediately.
- Reset pulsed in the second BUSY cycle: after the next edge MemEn=0, Gnt=0, Sel=0, RData=0, and no Done pulse occurs.
- ReqA dropped in the first BUSY cycle: the access still runs MEM_LAT cycles and DoneA pulses once.
